// File: rtl/xadc_temp_reader.sv
// XADC on-die temperature reader: waits for end-of-conversion, reads the temperature
// status register over DRP, averages 2^AVG_LOG2 samples and flags per-sample timeouts.
module xadc_temp_reader #(
  parameter bit          Simulacion  = 1'b0,
  parameter int          AVG_LOG2    = 2,
  parameter int          TIMEOUT_CYC = 1000,
  parameter logic [15:0] SIM_TEMP    = 16'hA000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic [15:0] XADC_data,
  output logic        XADC_ready,
  output logic        busy,
  output logic        timeout_err,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int          ACC_W     = 16 + AVG_LOG2;
  localparam logic [4:0]  N_SAMPLES = 5'(1 << AVG_LOG2);
  localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, WAIT_EOC, DRP_RD, WAIT_DRDY, DONE} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [15:0]        data_q;
  logic               ready_q, busy_q, terr_q, den_q;
  logic               eoc_s, drdy_s, tmo_last_s;
  logic [15:0]        sample_s;

  assign XADC_data   = data_q;
  assign XADC_ready  = ready_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign drp_den     = den_q;
  assign drp_dwe     = 1'b0;
  assign drp_daddr   = 7'h00;
  assign drp_di      = 16'h0000;

  // In simulation mode every wait is satisfied on its first cycle with SIM_TEMP as data.
  always_comb begin
    eoc_s      = Simulacion ? 1'b1 : eoc;
    drdy_s     = Simulacion ? 1'b1 : drp_drdy;
    sample_s   = Simulacion ? SIM_TEMP : drp_do;
    acc_d      = acc_q + ACC_W'(sample_s);
    cnt_d      = cnt_q + 5'd1;
    tmo_d      = tmo_q - 32'd1;
    tmo_last_s = (tmo_q <= 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 5'd0;
      tmo_q   <= 32'd0;
      data_q  <= 16'h0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      den_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= WAIT_EOC;
            acc_q   <= '0;
            cnt_q   <= 5'd0;
            tmo_q   <= TMO_LOAD;
            terr_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        // An event in the expiry cycle wins over the timeout.
        WAIT_EOC: begin
          if (eoc_s) begin
            state_q <= Simulacion ? WAIT_DRDY : DRP_RD;
            den_q   <= ~Simulacion;
            tmo_q   <= TMO_LOAD;
          end else if (tmo_last_s) begin
            state_q <= DONE;
            acc_q   <= '0;
            tmo_q   <= 32'd0;
            data_q  <= 16'hFFFF;
            terr_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q   <= tmo_d;
          end
        end
        DRP_RD: begin
          state_q <= WAIT_DRDY;
          tmo_q   <= TMO_LOAD;
        end
        WAIT_DRDY: begin
          if (drdy_s) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == N_SAMPLES) begin
              state_q <= DONE;
              data_q  <= 16'(acc_d >> AVG_LOG2);
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_EOC;
              tmo_q   <= TMO_LOAD;
            end
          end else if (tmo_last_s) begin
            state_q <= DONE;
            acc_q   <= '0;
            tmo_q   <= 32'd0;
            data_q  <= 16'hFFFF;
            terr_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q   <= tmo_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_temp_reader.sv
// Directed bench: three reader instances (single sample with short timeout, 4-sample
// average, simulation mode) driven from one linear stimulus sequence.
module tb_xadc_temp_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        eoc = 1'b0;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'h0000;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;

  logic [15:0] data_a, data_b, data_c, di_a, di_b, di_c;
  logic        ready_a, ready_b, ready_c, busy_a, busy_b, busy_c;
  logic        terr_a, terr_b, terr_c, den_a, den_b, den_c, dwe_a, dwe_b, dwe_c;
  logic [6:0]  daddr_a, daddr_b, daddr_c;

  xadc_temp_reader #(.Simulacion(1'b0), .AVG_LOG2(0), .TIMEOUT_CYC(20), .SIM_TEMP(16'hA000)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .XADC_data(data_a), .XADC_ready(ready_a),
    .busy(busy_a), .timeout_err(terr_a), .eoc(eoc), .drp_den(den_a), .drp_dwe(dwe_a),
    .drp_daddr(daddr_a), .drp_di(di_a), .drp_do(drp_do), .drp_drdy(drp_drdy));

  xadc_temp_reader #(.Simulacion(1'b0), .AVG_LOG2(2), .TIMEOUT_CYC(1000), .SIM_TEMP(16'hA000)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .XADC_data(data_b), .XADC_ready(ready_b),
    .busy(busy_b), .timeout_err(terr_b), .eoc(eoc), .drp_den(den_b), .drp_dwe(dwe_b),
    .drp_daddr(daddr_b), .drp_di(di_b), .drp_do(drp_do), .drp_drdy(drp_drdy));

  xadc_temp_reader #(.Simulacion(1'b1), .AVG_LOG2(1), .TIMEOUT_CYC(1000), .SIM_TEMP(16'hA000)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .XADC_data(data_c), .XADC_ready(ready_c),
    .busy(busy_c), .timeout_err(terr_c), .eoc(eoc), .drp_den(den_c), .drp_dwe(dwe_c),
    .drp_daddr(daddr_c), .drp_di(di_c), .drp_do(drp_do), .drp_drdy(drp_drdy));

  int vectors = 0;
  int miscompares = 0;
  int den_n_a = 0, den_n_b = 0, den_n_c = 0;
  int rdy_n_a = 0, rdy_n_b = 0, rdy_n_c = 0;
  int addr_bad = 0;

  // Pulse counters and DRP address monitor.
  always @(posedge clk) begin
    if (den_a === 1'b1) den_n_a <= den_n_a + 1;
    if (den_b === 1'b1) den_n_b <= den_n_b + 1;
    if (den_c === 1'b1) den_n_c <= den_n_c + 1;
    if (ready_a === 1'b1) rdy_n_a <= rdy_n_a + 1;
    if (ready_b === 1'b1) rdy_n_b <= rdy_n_b + 1;
    if (ready_c === 1'b1) rdy_n_c <= rdy_n_c + 1;
    if ((den_a === 1'b1 && daddr_a !== 7'h00) || (den_b === 1'b1 && daddr_b !== 7'h00))
      addr_bad <= addr_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int which);
    case (which)
      0: return ready_a;
      1: return ready_b;
      default: return ready_c;
    endcase
  endfunction

  task automatic wait_ready(input int which, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rdy_of(which) !== 1'b1 && n < max);
  endtask

  logic [15:0] samp [4] = '{16'h9000, 16'h9010, 16'h9020, 16'h9031};
  int n, d0, r0, d0b, r0b;

  initial begin
    // Reset values
    tick(); tick();
    check("rst_data", data_a, 16'h0000);
    check("rst_ready", ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_terr", terr_a, 1'b0);
    check("rst_den", den_a, 1'b0);
    check("rst_data_b", data_b, 16'h0000);
    reset = 1'b1;
    tick();

    // Single sample, eoc 5 cycles after acceptance
    req_a = 1'b1; tick(); req_a = 1'b0;
    check("acc_busy", busy_a, 1'b1);
    tick(); tick(); tick(); tick();
    eoc = 1'b1; check("den_before_eoc", den_a, 1'b0);
    tick(); eoc = 1'b0;
    check("den_after_eoc", den_a, 1'b1);
    check("daddr", daddr_a, 7'h00);
    tick();
    check("den_one_cycle", den_a, 1'b0);
    drp_drdy = 1'b1; drp_do = 16'h9C40;
    check("ready_before_drdy", ready_a, 1'b0);
    tick(); drp_drdy = 1'b0;
    check("ready_a", ready_a, 1'b1);
    check("data_9c40", data_a, 16'h9C40);
    check("busy_done", busy_a, 1'b0);
    tick();
    check("ready_pulse", ready_a, 1'b0);
    check("data_hold", data_a, 16'h9C40);
    check("den_count_1", den_n_a, 1);
    check("rdy_count_1", rdy_n_a, 1);

    // eoc/drdy while idle are ignored
    eoc = 1'b1; drp_drdy = 1'b1; drp_do = 16'h1234;
    tick(); tick();
    eoc = 1'b0; drp_drdy = 1'b0;
    tick();
    check("idle_busy", busy_a, 1'b0);
    check("idle_data", data_a, 16'h9C40);
    check("idle_den_cnt", den_n_a, 1);
    check("idle_rdy_cnt", rdy_n_a, 1);

    // req while busy is ignored (incl. req coincident with drdy)
    d0 = den_n_a; r0 = rdy_n_a;
    req_a = 1'b1; tick(); req_a = 1'b0;
    tick();
    req_a = 1'b1; tick(); req_a = 1'b0;
    eoc = 1'b1; tick(); eoc = 1'b0;
    check("busy_den", den_a, 1'b1);
    tick();
    req_a = 1'b1; drp_drdy = 1'b1; drp_do = 16'h8000;
    tick(); req_a = 1'b0; drp_drdy = 1'b0;
    check("busy_req_ready", ready_a, 1'b1);
    check("busy_req_data", data_a, 16'h8000);
    tick(); tick();
    check("busy_req_idle", busy_a, 1'b0);
    check("busy_req_den_n", den_n_a - d0, 1);
    check("busy_req_rdy_n", rdy_n_a - r0, 1);

    // Timeout after 20 cycles
    d0 = den_n_a;
    req_a = 1'b1; tick(); req_a = 1'b0;
    wait_ready(0, 40, n);
    check("tmo_cycles", n, 20);
    check("tmo_data", data_a, 16'hFFFF);
    check("tmo_err", terr_a, 1'b1);
    check("tmo_busy", busy_a, 1'b0);
    tick();
    check("tmo_sticky", terr_a, 1'b1);
    check("tmo_no_den", den_n_a - d0, 0);
    req_a = 1'b1; tick(); req_a = 1'b0;
    check("tmo_clear", terr_a, 1'b0);
    check("tmo_clear_busy", busy_a, 1'b1);

    // Reset in WAIT_DRDY, then a stray drdy
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    reset = 1'b0; tick();
    check("mid_rst_data", data_a, 16'h0000);
    check("mid_rst_ready", ready_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_terr", terr_a, 1'b0);
    check("mid_rst_den", den_a, 1'b0);
    r0 = rdy_n_a;
    reset = 1'b1; drp_drdy = 1'b1; drp_do = 16'h5555;
    tick(); drp_drdy = 1'b0;
    tick();
    check("post_rst_ready", ready_a, 1'b0);
    check("post_rst_rdy_n", rdy_n_a - r0, 0);
    req_a = 1'b1; tick(); req_a = 1'b0;
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    drp_drdy = 1'b1; drp_do = 16'h7FF0; tick(); drp_drdy = 1'b0;
    check("post_rst_ok", ready_a, 1'b1);
    check("post_rst_val", data_a, 16'h7FF0);
    tick();

    // Events in the expiry cycle count as success
    req_a = 1'b1; tick(); req_a = 1'b0;
    repeat (19) tick();
    eoc = 1'b1; tick(); eoc = 1'b0;
    check("edge_eoc_den", den_a, 1'b1);
    check("edge_eoc_terr", terr_a, 1'b0);
    check("edge_eoc_ready", ready_a, 1'b0);
    tick();
    repeat (19) tick();
    drp_drdy = 1'b1; drp_do = 16'h6660; tick(); drp_drdy = 1'b0;
    check("edge_drdy_ready", ready_a, 1'b1);
    check("edge_drdy_data", data_a, 16'h6660);
    check("edge_drdy_terr", terr_a, 1'b0);
    tick();

    // Four-sample average on instance B
    d0 = den_n_a; r0 = rdy_n_a; d0b = den_n_b; r0b = rdy_n_b;
    req_b = 1'b1; tick(); req_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eoc = 1'b1; tick(); eoc = 1'b0;
      tick();
      drp_drdy = 1'b1; drp_do = samp[i]; tick(); drp_drdy = 1'b0;
      if (i < 3) begin
        check("avg_mid_ready", ready_b, 1'b0);
        check("avg_mid_busy", busy_b, 1'b1);
      end
    end
    check("avg_ready", ready_b, 1'b1);
    check("avg_data", data_b, 16'h9018);
    tick();
    check("avg_den_n", den_n_b - d0b, 4);
    check("avg_rdy_n", rdy_n_b - r0b, 1);
    check("avg_a_den_quiet", den_n_a - d0, 0);
    check("avg_a_rdy_quiet", rdy_n_a - r0, 0);

    // Simulation-mode instance C with noise on the DRP inputs
    eoc = 1'b1; drp_drdy = 1'b1; drp_do = 16'h1111;
    req_c = 1'b1; tick(); req_c = 1'b0;
    wait_ready(2, 12, n);
    check("sim_cycles", n, 4);
    check("sim_data", data_c, 16'hA000);
    eoc = 1'b0; drp_drdy = 1'b0;
    tick();
    check("sim_den_n", den_n_c, 0);
    check("sim_rdy_n", rdy_n_c, 1);
    check("sim_busy", busy_c, 1'b0);

    check("drp_addr_bad", addr_bad, 0);
    check("dwe_all", {dwe_a, dwe_b, dwe_c}, 3'b000);
    check("di_a", di_a, 16'h0000);
    check("di_bc", {di_b, di_c}, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
